// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and data requesters,
// holding the winning request for the whole transaction, with a sticky response watchdog.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        err_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d, read_q, read_d, write_q, write_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] wmask_q, wmask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic d_req, gnt_i, gnt_d, busy;
  always_comb begin
    d_req = d_read | d_write;
    gnt_i = (state_q == IDLE) && i_read && (!d_req || last_d_q);
    gnt_d = (state_q == IDLE) && d_req && !gnt_i;
    busy = state_q != IDLE;
    state_d = gnt_i ? GNT_I : gnt_d ? GNT_D : (busy && mem_resp) ? IDLE : state_q;
    last_d_d = gnt_d ? 1'b1 : gnt_i ? 1'b0 : last_d_q;
    addr_d = gnt_i ? i_addr : gnt_d ? d_addr : addr_q;
    // a simultaneous read+write from the data side is treated as a write only
    read_d = gnt_i ? 1'b1 : gnt_d ? (d_read & ~d_write) : read_q;
    write_d = gnt_i ? 1'b0 : gnt_d ? d_write : write_q;
    wmask_d = gnt_i ? 4'h0 : gnt_d ? (d_write ? d_wmask : 4'h0) : wmask_q;
    wdata_d = gnt_d ? d_wdata : wdata_q;
    cnt_d = (gnt_i || gnt_d) ? '0 :
            (busy && !mem_resp && cnt_q != CW'(TIMEOUT_CYCLES)) ? cnt_q + CW'(1) : cnt_q;
    err_d = err_q | (cnt_d == CW'(TIMEOUT_CYCLES));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_d_q <= 1'b1;
      addr_q <= '0;
      read_q <= 1'b0;
      write_q <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      addr_q <= addr_d;
      read_q <= read_d;
      write_q <= write_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read = busy & read_q;
  assign mem_write = busy & write_q;
  assign mem_wmask = busy ? wmask_q : 4'h0;
  assign i_resp = (state_q == GNT_I) & mem_resp;
  assign d_resp = (state_q == GNT_D) & mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level
// round-robin model; inputs are driven on the falling edge and outputs checked 1 time unit later.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic i_read, i_resp, d_read, d_write, d_resp, mem_read, mem_write, mem_resp, err_timeout;
  logic [3:0] d_wmask, mem_wmask;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .err_timeout(err_timeout)
  );

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_addr = 0; d_addr = 0; d_wmask = 0; d_wdata = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); #1;
    n_cmp++;
    if ({i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wmask, mem_wdata, err_timeout} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got mem_addr=%h rd=%b wr=%b err=%b, want all zero", mem_addr, mem_read, mem_write, err_timeout);
    end
    rst = 0;
  endtask

  task automatic test_fetch_only();
    @(negedge clk); i_addr = 32'h4000_0000; i_read = 1; #1;
    n_cmp++;
    if (mem_read !== 1'b0) begin n_err++; $display("FAIL fetch_idle_cycle: mem_read=%b want 0", mem_read); end
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_read, mem_write, mem_addr} !== {2'b10, 32'h4000_0000}) begin
      n_err++; $display("FAIL fetch_issue: rd=%b wr=%b addr=%h want 1 0 40000000", mem_read, mem_write, mem_addr);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b00) begin n_err++; $display("FAIL fetch_wait: i_resp=%b d_resp=%b want 0 0", i_resp, d_resp); end
    @(negedge clk); mem_resp = 1; mem_rdata = 32'h0000_0013; #1;
    n_cmp++;
    if ({i_resp, i_rdata, d_resp} !== {1'b1, 32'h0000_0013, 1'b0}) begin
      n_err++; $display("FAIL fetch_resp: i_resp=%b i_rdata=%h d_resp=%b want 1 00000013 0", i_resp, i_rdata, d_resp);
    end
    @(negedge clk); mem_resp = 0; i_read = 0; #1;
    n_cmp++;
    if ({i_resp, mem_read, i_rdata} !== '0) begin
      n_err++; $display("FAIL fetch_done: i_resp=%b mem_read=%b i_rdata=%h want 0 0 0", i_resp, mem_read, i_rdata);
    end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk); i_addr = 32'h4000_0000; d_addr = 32'h4000_0010; i_read = 1; d_read = 1;
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h4000_0000}) begin
      n_err++; $display("FAIL tie_first_fetch: rd=%b addr=%h want 1 40000000", mem_read, mem_addr);
    end
    @(negedge clk); mem_resp = 1; mem_rdata = 32'h1111_1111; #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b10) begin n_err++; $display("FAIL tie_fetch_resp: i=%b d=%b want 1 0", i_resp, d_resp); end
    @(negedge clk); mem_resp = 0; i_read = 0; #1;
    n_cmp++;
    if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL tie_dead_cycle: rd=%b wr=%b want 0 0", mem_read, mem_write); end
    @(negedge clk); i_addr = 32'h4000_0020; i_read = 1; #1;
    n_cmp++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h4000_0010}) begin
      n_err++; $display("FAIL tie_data_second: rd=%b addr=%h want 1 40000010", mem_read, mem_addr);
    end
    @(negedge clk); mem_resp = 1; mem_rdata = 32'h2222_2222; #1;
    n_cmp++;
    if ({i_resp, d_resp, d_rdata} !== {2'b01, 32'h2222_2222}) begin
      n_err++; $display("FAIL tie_data_resp: i=%b d=%b d_rdata=%h want 0 1 22222222", i_resp, d_resp, d_rdata);
    end
    @(negedge clk); mem_resp = 0;
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h4000_0020}) begin
      n_err++; $display("FAIL tie_second_tie_fetch: rd=%b addr=%h want 1 40000020", mem_read, mem_addr);
    end
    @(negedge clk); mem_resp = 1; #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b10) begin n_err++; $display("FAIL tie_second_resp: i=%b d=%b want 1 0", i_resp, d_resp); end
    @(negedge clk); mem_resp = 0; i_read = 0; d_read = 0;
  endtask

  task automatic test_store();
    @(negedge clk); d_write = 1; d_addr = 32'h4000_0104; d_wmask = 4'b1100; d_wdata = 32'hABCD_0000;
    @(negedge clk); d_wdata = 32'hFFFF_FFFF; #1;
    n_cmp++;
    if ({mem_write, mem_read, mem_wmask, mem_addr, mem_wdata} !== {2'b10, 4'b1100, 32'h4000_0104, 32'hABCD_0000}) begin
      n_err++; $display("FAIL store_issue: wr=%b rd=%b mask=%b addr=%h wdata=%h", mem_write, mem_read, mem_wmask, mem_addr, mem_wdata);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (mem_wdata !== 32'hABCD_0000) begin n_err++; $display("FAIL store_hold: wdata=%h want abcd0000", mem_wdata); end
    @(negedge clk); mem_resp = 1; #1;
    n_cmp++;
    if ({d_resp, i_resp} !== 2'b10) begin n_err++; $display("FAIL store_resp: d=%b i=%b want 1 0", d_resp, i_resp); end
    @(negedge clk); mem_resp = 0; d_write = 0; #1;
    n_cmp++;
    if ({d_resp, mem_write, mem_wmask, mem_wdata} !== {2'b00, 4'b0000, 32'hABCD_0000}) begin
      n_err++; $display("FAIL store_idle: d=%b wr=%b mask=%b wdata=%h want 0 0 0000 abcd0000", d_resp, mem_write, mem_wmask, mem_wdata);
    end
  endtask

  task automatic test_withdraw();
    @(negedge clk); d_read = 1; d_addr = 32'h4000_0200;
    @(negedge clk); d_read = 0; #1;
    n_cmp++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h4000_0200}) begin
      n_err++; $display("FAIL withdraw_issue: rd=%b addr=%h want 1 40000200", mem_read, mem_addr);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (mem_read !== 1'b1) begin n_err++; $display("FAIL withdraw_held: rd=%b want 1", mem_read); end
    @(negedge clk); mem_resp = 1; mem_rdata = 32'h0000_0055; #1;
    n_cmp++;
    if ({d_resp, d_rdata} !== {1'b1, 32'h0000_0055}) begin
      n_err++; $display("FAIL withdraw_resp: d=%b d_rdata=%h want 1 00000055", d_resp, d_rdata);
    end
    @(negedge clk); mem_resp = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({mem_read, mem_write, d_resp} !== 3'b000) begin
        n_err++; $display("FAIL withdraw_idle: rd=%b wr=%b d=%b want 0 0 0", mem_read, mem_write, d_resp);
      end
    end
  endtask

  task automatic test_random();
    bit pi = 0, pd = 0, dr = 0, dw = 0, win_d, last_fetch = 0;
    logic [31:0] ia = 0, da = 0, dd = 0, e_addr, rd;
    logic [3:0] dm = 0;
    logic [1:0] op;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      @(negedge clk); mem_resp = 0;
      if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; ia = $urandom; end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1; da = $urandom; dd = $urandom; dm = 4'($urandom); op = 2'($urandom);
        dr = op[0] | ~op[1]; dw = op[1];
      end
      i_read = pi; i_addr = ia; d_read = pd & dr; d_write = pd & dw;
      d_addr = da; d_wdata = dd; d_wmask = dm;
      if (!pi && !pd) begin
        @(negedge clk); #1;
        n_cmp++;
        if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL rand_idle: rd=%b wr=%b want 0 0", mem_read, mem_write); end
        continue;
      end
      win_d = pd && (!pi || last_fetch);
      last_fetch = !win_d;
      e_addr = win_d ? da : ia;
      @(negedge clk); #1;
      n_cmp++;
      if ({mem_read, mem_write, mem_addr} !== {win_d ? (dr & ~dw) : 1'b1, win_d & dw, e_addr}) begin
        n_err++; $display("FAIL rand_issue it=%0d: rd=%b wr=%b addr=%h want win_d=%b addr=%h", it, mem_read, mem_write, mem_addr, win_d, e_addr);
      end
      if (win_d && dw) begin
        n_cmp++;
        if ({mem_wmask, mem_wdata} !== {dm, dd}) begin
          n_err++; $display("FAIL rand_wdata it=%0d: mask=%b wdata=%h want %b %h", it, mem_wmask, mem_wdata, dm, dd);
        end
      end
      if (win_d) begin d_addr = $urandom; d_wdata = $urandom; end else i_addr = $urandom;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); #1;
        n_cmp++;
        if ({i_resp, d_resp, mem_addr} !== {2'b00, e_addr}) begin
          n_err++; $display("FAIL rand_wait it=%0d: i=%b d=%b addr=%h want 0 0 %h", it, i_resp, d_resp, mem_addr, e_addr);
        end
      end
      @(negedge clk); rd = $urandom; mem_resp = 1; mem_rdata = rd; #1;
      n_cmp++;
      if ({i_resp, i_rdata, d_resp, d_rdata} !== (win_d ? {33'd0, 1'b1, rd} : {1'b1, rd, 33'd0})) begin
        n_err++; $display("FAIL rand_resp it=%0d: i=%b %h d=%b %h want win_d=%b data=%h", it, i_resp, i_rdata, d_resp, d_rdata, win_d, rd);
      end
      if (win_d) pd = 0; else pi = 0;
    end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL rand_no_timeout: err=%b want 0", err_timeout); end
  endtask

  task automatic test_watchdog();
    do_reset();
    @(negedge clk); i_read = 1; i_addr = 32'h4000_0300;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({mem_read, err_timeout} !== {1'b1, k > 8}) begin
        n_err++; $display("FAIL watchdog_cycle%0d: rd=%b err=%b want 1 %b", k, mem_read, err_timeout, k > 8);
      end
    end
    @(negedge clk); mem_resp = 1; #1;
    n_cmp++;
    if ({i_resp, err_timeout} !== 2'b11) begin n_err++; $display("FAIL watchdog_late_resp: i=%b err=%b want 1 1", i_resp, err_timeout); end
    @(negedge clk); mem_resp = 0; i_read = 0; #1;
    n_cmp++;
    if ({mem_read, err_timeout} !== 2'b01) begin n_err++; $display("FAIL watchdog_sticky: rd=%b err=%b want 0 1", mem_read, err_timeout); end
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; #1;
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL watchdog_rst_clear: err=%b want 0", err_timeout); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); d_write = 1; d_addr = 32'h4000_0400; d_wmask = 4'hF; d_wdata = 32'h1234_5678;
    @(negedge clk); #1;
    n_cmp++;
    if (mem_write !== 1'b1) begin n_err++; $display("FAIL rstmid_issue: wr=%b want 1", mem_write); end
    @(negedge clk); rst = 1; d_write = 0;
    @(negedge clk); rst = 0; #1;
    n_cmp++;
    if ({i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wmask, mem_wdata, err_timeout} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: addr=%h wr=%b mask=%b wdata=%h want all zero", mem_addr, mem_write, mem_wmask, mem_wdata);
    end
    @(negedge clk); mem_resp = 1; mem_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++;
    if ({i_resp, d_resp, i_rdata, d_rdata} !== '0) begin
      n_err++; $display("FAIL rstmid_stale_resp: i=%b d=%b want 0 0", i_resp, d_resp);
    end
    @(negedge clk); mem_resp = 0; #1;
    n_cmp++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_idle: rd=%b wr=%b i=%b d=%b want 0", mem_read, mem_write, i_resp, d_resp);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch_only();
    test_tie();
    test_store();
    test_withdraw();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory interface between an instruction-fetch requester (read-only) and a data requester (read/write) of the multicycle RV32I core.
- Sits between the core's split fetch/data ports and the memory model or cache.
- Uses round-robin arbitration and latches the winning request for the whole transaction.
- A watchdog flags a memory that never responds.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles a granted transaction may wait for mem_resp before err_timeout sets. Minimum 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_addr  in  32  fetch address
i_read  in  1  fetch request
i_rdata  out  32  fetch read data
i_resp  out  1  fetch done, 1-cycle pulse
d_addr  in  32  data address
d_read  in  1  data read request
d_write  in  1  data write request
d_wmask  in  4  data byte write mask
d_wdata  in  32  data write data
d_rdata  out  32  data read data
d_resp  out  1  data done, 1-cycle pulse
mem_addr  out  32  downstream address
mem_read  out  1  downstream read
mem_write  out  1  downstream write
mem_wmask  out  4  downstream write mask
mem_wdata  out  32  downstream write data
mem_rdata  in  32  downstream read data
mem_resp  in  1  downstream done
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Requester protocol: a requester holds its request and its address/data until its resp pulse. The downstream memory behaves the same way.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Sample i_read and d_req = d_read|d_write.
  - None requesting: stay in IDLE.
  - One requesting: grant it.
  - Both requesting: grant the requester not granted last. The last-grant pointer resets to "data", so fetch wins the first tie.
  - On a grant: latch addr, read/write, wmask and wdata into holding registers, update the last-grant pointer, and move to GNT_x.
  - No downstream request is driven in IDLE.
- GNT_I / GNT_D:
  - mem_* outputs are driven only from the holding registers; requester input changes are ignored.
  - mem_read/mem_write stay high until mem_resp.
  - On mem_resp: pulse the granted side's resp for exactly that cycle, pass mem_rdata combinationally to that side's rdata, and return to IDLE.
  - The non-granted resp stays 0.
- Latency: the request is seen in cycle N, mem_read/mem_write rise in N+1, and the resp pulse arrives in the same cycle as mem_resp. Minimum 2 cycles per transaction; one dead IDLE cycle separates back-to-back transactions.
- Illegal d_read&d_write both high: latch as a write only (mem_read=0). d_wmask=0 with d_write is forwarded unchanged.
- Idle outputs:
  - mem_read = mem_write = 0 and mem_wmask = 0.
  - mem_addr and mem_wdata hold their last latched values (0 after reset).
  - i_rdata and d_rdata are 0 whenever the matching resp is 0.
- Requester drops its request mid-grant: the latched transaction still completes downstream and the resp pulse is still issued.
- mem_resp in IDLE: ignored, no resp pulse generated.
- Watchdog:
  - A counter clears on entering GNT_x and increments each GNT cycle without mem_resp.
  - When it reaches TIMEOUT_CYCLES, err_timeout sets and stays set until rst. The transaction keeps waiting; there is no abort.
  - The counter saturates and does not wrap.
- Reset (including mid-transaction):
  - State goes to IDLE and the last-grant pointer to data.
  - All holding registers, the counter and err_timeout go to 0; all outputs go to 0.
  - A mem_resp arriving after reset is ignored.

Test Plan:
- Fetch only: i_addr=0x40000000, i_read=1, memory responds 2 cycles after mem_read rises with 0x00000013 -> mem_read rises 1 cycle after i_read, mem_addr=0x40000000, i_resp pulses once with i_rdata=0x00000013, d_resp=0.
- Simultaneous first requests: i_read and d_read at 0x40000010 rise in the same cycle after reset -> fetch granted first; data issued after i_resp plus one IDLE cycle; the next tie grants fetch again.
- Store pass-through: d_write=1, d_addr=0x40000104, d_wmask=4'b1100, d_wdata=0xABCD0000, with d_wdata changed to 0xFFFFFFFF on the cycle after the grant -> mem_wdata stays 0xABCD0000, mem_wmask=1100, mem_read=0, d_resp pulses once.
- Requester withdrawal: d_read dropped 1 cycle after the grant -> downstream read completes, d_resp still pulses, then the arbiter returns to IDLE with no new request.
- Watchdog: TIMEOUT_CYCLES=8, memory never responds -> err_timeout rises after 8 GNT cycles and stays high after mem_resp finally arrives; rst clears it.
- Reset mid-transaction: rst asserted in GNT_D with mem_write=1 -> next cycle all outputs are 0; a stale mem_resp one cycle later produces no i_resp or d_resp pulse.
